spart_bus_sequencer: RTL and testbench

Owns the SPART processor-side bus (iocs/iorw/ioaddr/databus). It is the only master on that bus.
- Programs the baud divisor after reset and on every br_cfg change.
- Reads received bytes when rda is set and buffers them in a small FIFO.
- Writes buffered bytes back to the SPART transmitter when tbr is set (echo path).
- Arbitrates the three activities with fixed priority, one transaction at a time.

---
 rtl/spart_pkg.sv | 36 +++
 rtl/spart_byte_fifo.sv | 51 +++++
 rtl/spart_bus_sequencer.sv | 147 ++++++++++++++
 tb/tb_spart_bus_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared SPART bus constants, sequencer state encoding and baud divisor helper.
// Pure declarations: no latency, no flow control.
package spart_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_DB_LO  = 2'd2;
   localparam logic [1:0] ADDR_DB_HI  = 2'd3;

   localparam int unsigned BAUD_4800  = 4800;
   localparam int unsigned BAUD_9600  = 9600;
   localparam int unsigned BAUD_19200 = 19200;
   localparam int unsigned BAUD_38400 = 38400;

   typedef enum logic [2:0] {
      IDLE,
      CFG_LO,
      CFG_HI,
      RX_RD,
      TX_WR,
      GAP
   } seq_state_t;

   // SPART samples 16x per bit, so the divisor counts clocks per sample tick.
   function automatic logic [15:0] divisor(input int unsigned clk_hz, input logic [1:0] cfg);
      int unsigned baud;
      case (cfg)
         2'b00:   baud = BAUD_4800;
         2'b01:   baud = BAUD_9600;
         2'b10:   baud = BAUD_19200;
         default: baud = BAUD_38400;
      endcase
      return 16'((clk_hz / (16 * baud)) - 1);
   endfunction

endpackage

// File: rtl/spart_byte_fifo.sv
// Byte FIFO for the echo path; 1-cycle write-to-read latency, count via wrap-bit pointers.
// Backpressure: push ignored when full, pop ignored when empty.
module spart_byte_fifo #(
   parameter int FIFO_DEPTH = 8,
   localparam int AW = $clog2(FIFO_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;

   assign count = wr_q - rd_q;
   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign empty = (wr_q == rd_q);
   assign dout  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push && !full)
         wr_d = wr_q + (AW+1)'(1);
      if (pop && !empty)
         rd_d = rd_q + (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/spart_bus_sequencer.sv
// Sole SPART bus master: divisor programming, RX drain into FIFO, TX echo; 1-cycle IDLE-to-bus, GAP after each access.
// Backpressure: rda ignored while FIFO full, tbr ignored while empty. SPART_SEQ_CASEFOLD_EN uppercases echoed a-z.
module spart_bus_sequencer
   import spart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    br_cfg,
   output logic                          iocs,
   output logic                          iorw,
   input  logic                          rda,
   input  logic                          tbr,
   output logic [1:0]                    ioaddr,
   inout  wire  [7:0]                    databus,
   output logic                          cfg_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   seq_state_t  state_q, state_d;
   logic        iocs_q, iocs_d;
   logic        iorw_q, iorw_d;
   logic [1:0]  ioaddr_q, ioaddr_d;
   logic [7:0]  dat_q, dat_d;
   logic [1:0]  br_cfg_q;
   logic [1:0]  prog_cfg_q, prog_cfg_d;
   logic [1:0]  last_cfg_q, last_cfg_d;
   logic        cfg_pending_q, cfg_pending_d;
   logic        cfg_done_q, cfg_done_d;

   logic        fifo_full, fifo_empty;
   logic [7:0]  fifo_dout;
   logic [15:0] div_sel;
   logic        cfg_req;

   function automatic logic [7:0] tx_byte(input logic [7:0] b);
`ifdef SPART_SEQ_CASEFOLD_EN
      return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
      return b;
`endif
   endfunction

   spart_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (state_q == RX_RD),
      .pop   (state_q == TX_WR),
      .din   (databus),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Low byte is loaded from the live setting in IDLE, high byte from the latched one in CFG_LO.
   assign div_sel = divisor(CLK_HZ, (state_q == IDLE) ? br_cfg_q : prog_cfg_q);
   // Look at the raw mismatch too, so a fresh br_cfg change beats a same-cycle rda.
   assign cfg_req = cfg_pending_q || (br_cfg_q != last_cfg_q);

   always_comb begin
      state_d       = state_q;
      iocs_d        = 1'b0;
      iorw_d        = 1'b1;
      ioaddr_d      = ADDR_DATA;
      dat_d         = dat_q;
      prog_cfg_d    = prog_cfg_q;
      last_cfg_d    = last_cfg_q;
      cfg_pending_d = cfg_pending_q;
      cfg_done_d    = cfg_done_q;
      if (br_cfg_q != last_cfg_q) begin
         cfg_pending_d = 1'b1;
         cfg_done_d    = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (cfg_req) begin
               state_d    = CFG_LO;
               iocs_d     = 1'b1;
               iorw_d     = 1'b0;
               ioaddr_d   = ADDR_DB_LO;
               prog_cfg_d = br_cfg_q;
               dat_d      = div_sel[7:0];
            end else if (rda && !fifo_full) begin
               state_d = RX_RD;
               iocs_d  = 1'b1;
            end else if (tbr && !fifo_empty) begin
               state_d = TX_WR;
               iocs_d  = 1'b1;
               iorw_d  = 1'b0;
               dat_d   = tx_byte(fifo_dout);
            end
         end
         CFG_LO: begin
            state_d  = CFG_HI;
            iocs_d   = 1'b1;
            iorw_d   = 1'b0;
            ioaddr_d = ADDR_DB_HI;
            dat_d    = div_sel[15:8];
         end
         CFG_HI: begin
            state_d    = GAP;
            last_cfg_d = prog_cfg_q;
            if (br_cfg_q == prog_cfg_q) begin
               cfg_pending_d = 1'b0;
               cfg_done_d    = 1'b1;
            end
         end
         RX_RD, TX_WR: state_d = GAP;
         default:      state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      br_cfg_q <= br_cfg;
      if (!rst) begin
         state_q       <= IDLE;
         iocs_q        <= 1'b0;
         iorw_q        <= 1'b1;
         ioaddr_q      <= ADDR_DATA;
         dat_q         <= 8'h00;
         prog_cfg_q    <= 2'b00;
         last_cfg_q    <= 2'b00;
         cfg_pending_q <= 1'b1;
         cfg_done_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         iocs_q        <= iocs_d;
         iorw_q        <= iorw_d;
         ioaddr_q      <= ioaddr_d;
         dat_q         <= dat_d;
         prog_cfg_q    <= prog_cfg_d;
         last_cfg_q    <= last_cfg_d;
         cfg_pending_q <= cfg_pending_d;
         cfg_done_q    <= cfg_done_d;
      end
   end

   assign iocs     = iocs_q;
   assign iorw     = iorw_q;
   assign ioaddr   = ioaddr_q;
   assign cfg_done = cfg_done_q;
   assign databus  = (iocs_q && !iorw_q) ? dat_q : 8'bz;

endmodule

// File: tb/tb_spart_bus_sequencer.sv
// Directed bench for spart_bus_sequencer acting as the SPART side of the bus.
module tb_spart_bus_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] br_cfg = 2'b01;
   logic       rda = 1'b0;
   logic       tbr = 1'b0;
   logic [7:0] rx_dat = 8'h00;
   wire        iocs, iorw, cfg_done;
   wire [1:0]  ioaddr;
   wire [7:0]  databus;
   wire [3:0]  fifo_count;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   assign databus = (iocs && iorw) ? rx_dat : 8'bz;

   spart_bus_sequencer #(.CLK_HZ(50000000), .FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .br_cfg     (br_cfg),
      .iocs       (iocs),
      .iorw       (iorw),
      .rda        (rda),
      .tbr        (tbr),
      .ioaddr     (ioaddr),
      .databus    (databus),
      .cfg_done   (cfg_done),
      .fifo_count (fifo_count)
   );

   typedef struct { logic [1:0] cfg; logic [7:0] lo; logic [7:0] hi; } cfg_vec_t;
   typedef struct { logic [7:0] rx; logic [7:0] tx; } echo_vec_t;

   cfg_vec_t  cfg_tab[4];
   echo_vec_t echo_tab[4];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic next_txn(input string name, output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (iocs !== 1'b1 && waited < 50);
      check({name, "_seen"}, {15'd0, iocs}, 16'd1);
   endtask

   task automatic check_wr(input string name, input logic [1:0] a, input logic [7:0] d);
      check(name, {5'd0, ioaddr, iorw, databus}, {5'd0, a, 1'b0, d});
   endtask

   task automatic rx_byte(input string name, input logic [7:0] b, output int waited);
      rx_dat = b;
      rda    = 1'b1;
      next_txn(name, waited);
      check(name, {13'd0, ioaddr, iorw}, {13'd0, 2'd0, 1'b1});
      @(negedge clk);
      rda = 1'b0;
   endtask

   task automatic watch_quiet(input string name, input int cycles);
      int hits = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (iocs) hits++;
      end
      check(name, 16'(hits), 16'd0);
   endtask

   initial begin
      int w;

      cfg_tab[0] = '{2'b00, 8'h8A, 8'h02};
      cfg_tab[1] = '{2'b10, 8'hA1, 8'h00};
      cfg_tab[2] = '{2'b11, 8'h50, 8'h00};
      cfg_tab[3] = '{2'b01, 8'h44, 8'h01};
`ifdef SPART_SEQ_CASEFOLD_EN
      echo_tab[0] = '{8'h61, 8'h41};
      echo_tab[1] = '{8'h5A, 8'h5A};
      echo_tab[2] = '{8'h7B, 8'h7B};
      echo_tab[3] = '{8'h7A, 8'h5A};
`else
      echo_tab[0] = '{8'h61, 8'h61};
      echo_tab[1] = '{8'h5A, 8'h5A};
      echo_tab[2] = '{8'h7B, 8'h7B};
      echo_tab[3] = '{8'h7A, 8'h7A};
`endif

      repeat (3) @(negedge clk);
      check("reset_state", {6'd0, iocs, iorw, ioaddr, (databus === 8'hzz), cfg_done, fifo_count},
            {6'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'd0});

      rst = 1'b1;
      next_txn("init_lo", w);
      check("init_latency", 16'(w), 16'd1);
      check_wr("init_lo", 2'd2, 8'h44);
      @(negedge clk);
      check_wr("init_hi", 2'd3, 8'h01);
      @(negedge clk);
      check("init_gap_done", {14'd0, iocs, cfg_done}, 16'd1);

      foreach (cfg_tab[i]) begin
         br_cfg = cfg_tab[i].cfg;
         next_txn($sformatf("cfg%0d_lo", i), w);
         check_wr($sformatf("cfg%0d_lo", i), 2'd2, cfg_tab[i].lo);
         check($sformatf("cfg%0d_done_clr", i), {15'd0, cfg_done}, 16'd0);
         @(negedge clk);
         check_wr($sformatf("cfg%0d_hi", i), 2'd3, cfg_tab[i].hi);
         @(negedge clk);
         check($sformatf("cfg%0d_gap_done", i), {14'd0, iocs, cfg_done}, 16'd1);
      end

      br_cfg = 2'b11;
      @(negedge clk);
      rda    = 1'b1;
      rx_dat = 8'h41;
      next_txn("pri_lo", w);
      check_wr("pri_lo", 2'd2, 8'h50);
      @(negedge clk);
      check_wr("pri_hi", 2'd3, 8'h00);
      rx_byte("rx_41", 8'h41, w);
      rx_byte("rx_42", 8'h42, w);
      check("rx_spacing_42", 16'(w), 16'd2);
      rx_byte("rx_43", 8'h43, w);
      check("rx_spacing_43", 16'(w), 16'd2);
      repeat (3) @(negedge clk);
      check("count_after_rx", {12'd0, fifo_count}, 16'd3);

      tbr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_txn($sformatf("tx%0d", i), w);
         check_wr($sformatf("tx%0d", i), 2'd0, 8'h41 + 8'(i));
      end
      watch_quiet("tx_empty_quiet", 10);
      check("count_after_tx", {12'd0, fifo_count}, 16'd0);
      tbr = 1'b0;

      foreach (echo_tab[i]) begin
         rx_byte($sformatf("echo%0d_rx", i), echo_tab[i].rx, w);
         tbr = 1'b1;
         next_txn($sformatf("echo%0d_tx", i), w);
         check_wr($sformatf("echo%0d_tx", i), 2'd0, echo_tab[i].tx);
         tbr = 1'b0;
      end

      repeat (3) @(negedge clk);
      for (int i = 0; i < 8; i++)
         rx_byte($sformatf("fill%0d", i), 8'h10 + 8'(i), w);
      rda    = 1'b1;
      rx_dat = 8'hEE;
      watch_quiet("full_quiet", 20);
      check("count_full", {12'd0, fifo_count}, 16'd8);
      rda = 1'b0;

      br_cfg = 2'b00;
      next_txn("rst_lo", w);
      check_wr("rst_lo", 2'd2, 8'h8A);
      rst = 1'b0;
      @(negedge clk);
      check("rst_abort", {9'd0, iocs, (databus === 8'hzz), fifo_count, cfg_done},
            {9'd0, 1'b0, 1'b1, 4'd0, 1'b0});
      rst = 1'b1;
      next_txn("reprog_lo", w);
      check_wr("reprog_lo", 2'd2, 8'h8A);
      @(negedge clk);
      check_wr("reprog_hi", 2'd3, 8'h02);
      @(negedge clk);
      check("reprog_done", {14'd0, iocs, cfg_done}, 16'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
